// File: rtl/ps2_rx_packet.sv
// Host-side PS/2 receiver: filtered frame capture, grouping of PKT_BYTES bytes into one packet.
// Optional ACK filter is enabled by defining PS2_RX_ACK_FILTER_EN.
module ps2_rx_packet #(
    parameter int         FILT_LEN    = 4,
    parameter int         TIMEOUT_CYC = 100000,
    parameter int         PKT_BYTES   = 3,
    parameter logic [7:0] ACK_BYTE    = 8'hFA
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic                   PS2CLK,
    input  logic                   PS2DATA,
    output logic                   PS2CLKOUT,
    output logic [8*PKT_BYTES-1:0] PKT_DATA,
    output logic                   PKT_VALID,
    input  logic                   PKT_READY,
    output logic [2:0]             BYTE_CNT,
    output logic                   ERR_PARITY,
    output logic                   ERR_FRAME,
    output logic                   ERR_TIMEOUT,
    output logic                   ACK_SEEN
);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, HOLD} state_t;

    state_t        state, state_nx;
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk, filt_flip, sample;
    logic [FW-1:0] filt_cnt;
    logic          start_bit;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [2:0]    byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_run, tmo_hit, is_ack, pkt_last;
    logic          store, err_par, err_frm, tmo, abort, ack, accept;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2CLK;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2DATA;
            dat_s2 <= dat_s1;
        end
    end

    // New level is taken only after FILT_LEN consecutive cycles of disagreement.
    assign filt_flip = (clk_s2 != filt_clk) && (filt_cnt == FW'(FILT_LEN - 1));
    assign sample    = filt_flip && filt_clk;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

`ifdef PS2_RX_ACK_FILTER_EN
    assign is_ack = (byte_cnt == 3'd0) && (shreg == ACK_BYTE);
`else
    assign is_ack = 1'b0;
`endif

    assign pkt_last = (byte_cnt == 3'(PKT_BYTES - 1));
    assign tmo_run  = ((state != IDLE) || (byte_cnt != 3'd0)) && (state != HOLD);
    assign tmo_hit  = tmo_run && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        store    = 1'b0;
        err_par  = 1'b0;
        err_frm  = 1'b0;
        tmo      = 1'b0;
        abort    = 1'b0;
        ack      = 1'b0;
        accept   = 1'b0;
        if (state == HOLD) begin
            if (PKT_READY) begin
                accept   = 1'b1;
                state_nx = IDLE;
            end
        end else if (!EN) begin
            abort    = 1'b1;
            state_nx = IDLE;
        end else if (tmo_hit) begin
            tmo      = 1'b1;
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:   if (sample) state_nx = START;
                START:  if (start_bit) begin
                            err_frm  = 1'b1;
                            state_nx = IDLE;
                        end else begin
                            state_nx = DATA;
                        end
                DATA:   if (sample && bit_cnt == 3'd7) state_nx = PARITY;
                PARITY: if (sample) begin
                            if (^{shreg, dat_s2}) state_nx = STOP;
                            else begin
                                err_par  = 1'b1;
                                state_nx = IDLE;
                            end
                        end
                STOP:   if (sample) begin
                            if (!dat_s2) begin
                                err_frm  = 1'b1;
                                state_nx = IDLE;
                            end else if (is_ack) begin
                                ack      = 1'b1;
                                state_nx = IDLE;
                            end else begin
                                store    = 1'b1;
                                state_nx = pkt_last ? HOLD : IDLE;
                            end
                        end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        PKT_VALID = (state == HOLD);
        PS2CLKOUT = EN && (state != HOLD);
        BYTE_CNT  = byte_cnt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            start_bit   <= 1'b1;
            shreg       <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            PKT_DATA    <= '0;
            tmo_cnt     <= '0;
            ERR_PARITY  <= 1'b0;
            ERR_FRAME   <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
            ACK_SEEN    <= 1'b0;
        end else begin
            ERR_PARITY  <= err_par;
            ERR_FRAME   <= err_frm;
            ERR_TIMEOUT <= tmo;
            ACK_SEEN    <= ack;
            if (state == IDLE && sample) start_bit <= dat_s2;
            if (state == START) bit_cnt <= '0;
            if (state == DATA && sample) begin
                shreg   <= {dat_s2, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (store) begin
                for (int k = 0; k < PKT_BYTES; k++)
                    if (byte_cnt == 3'(k)) PKT_DATA[8*k +: 8] <= shreg;
                byte_cnt <= byte_cnt + 1'b1;
            end else if (accept || abort || tmo || err_par || err_frm) begin
                byte_cnt <= '0;
            end
            if (sample || !tmo_run || tmo) tmo_cnt <= '0;
            else                           tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
endmodule
